// File: rtl/id_ex_stage_pipe.sv
// id_ex_stage_pipe
//   Decode stage of the IF-ID-EX-WB core. It holds the architectural
//   register file and selects each source operand from one of three places.
//   An ALU result that is still in EX is forwarded first. A value being
//   written back in WB this cycle is bypassed next. Otherwise the operand
//   comes from the register file. A load still in EX cannot be forwarded,
//   so a dependent instruction is held for one bubble. The operands,
//   destination, PC+4 and control word are then registered for EX.
//
// Ports
//   clk, rst_n             clock (rising edge) and async active-low reset
//   instr_valid_i/ready_o  handshake with IF
//   instr_i, pc_plus4_i    instruction word (rs1=[19:15], rs2=[24:20], rd=[11:7]) and PC+4
//   ctrl_i                 decoded control bundle carried through to EX
//   rs1/rs2_used_i         the instruction actually reads that source
//   rd_wen_i, is_load_i    the instruction writes rd / is a load
//   flush_i                drop the instruction in ID (taken branch in EX)
//   ex_ready_i             EX consumes its occupant this cycle
//   ex_result_i            result of the EX occupant, forwarding source
//   wb_wen_i/waddr_i/wdata_i  register file write port from WB
//   ex_valid_o .. ctrl_o   ID/EX pipeline register contents
//   bubble_cnt_o           saturating count of load-use bubbles
module id_ex_stage_pipe #(
   parameter int WORD_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int CTRL_WIDTH = 24,
   parameter int CNT_WIDTH  = 16,
   localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  logic [WORD_WIDTH-1:0] instr_i,
   input  logic [WORD_WIDTH-1:0] pc_plus4_i,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic                  rd_wen_i,
   input  logic                  is_load_i,
   input  logic                  flush_i,
   input  logic                  ex_ready_i,
   input  logic [WORD_WIDTH-1:0] ex_result_i,
   input  logic                  wb_wen_i,
   input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
   input  logic [WORD_WIDTH-1:0] wb_wdata_i,
   output logic                  ex_valid_o,
   output logic [WORD_WIDTH-1:0] rdata1_o,
   output logic [WORD_WIDTH-1:0] rdata2_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic                  rd_wen_o,
   output logic                  is_load_o,
   output logic [WORD_WIDTH-1:0] pc_plus4_o,
   output logic [CTRL_WIDTH-1:0] ctrl_o,
   output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [WORD_WIDTH-1:0] regs_q [NUM_REGS];
   logic [WORD_WIDTH-1:0] regs_d [NUM_REGS];

   logic                  ex_valid_q,  ex_valid_d;
   logic [WORD_WIDTH-1:0] rdata1_q,    rdata1_d;
   logic [WORD_WIDTH-1:0] rdata2_q,    rdata2_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
   logic                  rd_wen_q,    rd_wen_d;
   logic                  is_load_q,   is_load_d;
   logic [WORD_WIDTH-1:0] pc_plus4_q,  pc_plus4_d;
   logic [CTRL_WIDTH-1:0] ctrl_q,      ctrl_d;
   logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;

   logic [ADDR_WIDTH-1:0] rs1, rs2, rd;
   logic [WORD_WIDTH-1:0] operand1, operand2;
   logic                  ex_fwd_ok, hazard, advance;
   logic                  unused_instr_bits;

   // Only the low ADDR_WIDTH bits of each register field are used. With
   // NUM_REGS=16 this folds x16..x31 onto x0..x15.
   assign rs1 = instr_i[15 +: ADDR_WIDTH];
   assign rs2 = instr_i[20 +: ADDR_WIDTH];
   assign rd  = instr_i[7 +: ADDR_WIDTH];
   assign unused_instr_bits = ^instr_i;

   // A load's EX-stage result is only an address, so it must never be forwarded.
   assign ex_fwd_ok = ex_valid_q && rd_wen_q && !is_load_q;

   assign operand1 = (ex_fwd_ok && rd_addr_q == rs1 && rs1 != '0) ? ex_result_i :
                     (wb_wen_i && wb_waddr_i == rs1 && rs1 != '0)  ? wb_wdata_i  :
                     regs_q[rs1];
   assign operand2 = (ex_fwd_ok && rd_addr_q == rs2 && rs2 != '0) ? ex_result_i :
                     (wb_wen_i && wb_waddr_i == rs2 && rs2 != '0)  ? wb_wdata_i  :
                     regs_q[rs2];

   assign hazard = ex_valid_q && is_load_q && rd_wen_q && rd_addr_q != '0 &&
                   ((rs1_used_i && rd_addr_q == rs1) || (rs2_used_i && rd_addr_q == rs2));
   assign advance = !ex_valid_q || ex_ready_i;

   // A flush discards the ID instruction, so a pending hazard must not block it.
   assign instr_ready_o = advance && (!hazard || flush_i);

   always_comb begin
      regs_d = regs_q;
      if (wb_wen_i && wb_waddr_i != '0) begin
         regs_d[wb_waddr_i] = wb_wdata_i;
      end
   end

   // Bubbles clear only the valid and control fields. The data fields keep
   // their old contents because EX ignores them.
   always_comb begin
      ex_valid_d   = ex_valid_q;
      rdata1_d     = rdata1_q;
      rdata2_d     = rdata2_q;
      rd_addr_d    = rd_addr_q;
      rd_wen_d     = rd_wen_q;
      is_load_d    = is_load_q;
      pc_plus4_d   = pc_plus4_q;
      ctrl_d       = ctrl_q;
      bubble_cnt_d = bubble_cnt_q;
      if (advance) begin
         if (flush_i || !instr_valid_i || hazard) begin
            ex_valid_d = 1'b0;
            rd_wen_d   = 1'b0;
            is_load_d  = 1'b0;
            ctrl_d     = '0;
            if (!flush_i && instr_valid_i && hazard && bubble_cnt_q != '1) begin
               bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
         end else begin
            ex_valid_d = 1'b1;
            rdata1_d   = operand1;
            rdata2_d   = operand2;
            rd_addr_d  = rd;
            rd_wen_d   = rd_wen_i;
            is_load_d  = is_load_i;
            pc_plus4_d = pc_plus4_i;
            ctrl_d     = ctrl_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q       <= '{default: '0};
         ex_valid_q   <= 1'b0;
         rdata1_q     <= '0;
         rdata2_q     <= '0;
         rd_addr_q    <= '0;
         rd_wen_q     <= 1'b0;
         is_load_q    <= 1'b0;
         pc_plus4_q   <= '0;
         ctrl_q       <= '0;
         bubble_cnt_q <= '0;
      end else begin
         regs_q       <= regs_d;
         ex_valid_q   <= ex_valid_d;
         rdata1_q     <= rdata1_d;
         rdata2_q     <= rdata2_d;
         rd_addr_q    <= rd_addr_d;
         rd_wen_q     <= rd_wen_d;
         is_load_q    <= is_load_d;
         pc_plus4_q   <= pc_plus4_d;
         ctrl_q       <= ctrl_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid_o   = ex_valid_q;
   assign rdata1_o     = rdata1_q;
   assign rdata2_o     = rdata2_q;
   assign rd_addr_o    = rd_addr_q;
   assign rd_wen_o     = rd_wen_q;
   assign is_load_o    = is_load_q;
   assign pc_plus4_o   = pc_plus4_q;
   assign ctrl_o       = ctrl_q;
   assign bubble_cnt_o = bubble_cnt_q;

   // A taken branch is resolved by the EX occupant, which therefore always leaves EX.
   flush_needs_ex_ready: assert property (@(posedge clk) disable iff (!rst_n) flush_i |-> ex_ready_i);

endmodule

// File: tb/tb_id_ex_stage_pipe.sv
// tb_id_ex_stage_pipe
//   Table of per-cycle vectors for the default configuration, a scoreboard of
//   expected ID/EX contents, and hand sequences for mid-stream reset and a
//   16-register / 2-bit-counter instance.
module tb_id_ex_stage_pipe;

   localparam int KIND_BUBBLE = 0;
   localparam int KIND_LOAD   = 1;
   localparam int KIND_HOLD   = 2;

   logic clk = 1'b0;
   logic rst_n;

   logic        instr_valid, instr_ready, rs1_used, rs2_used, rd_wen, is_load;
   logic        flush, ex_ready, wb_wen, ex_valid, rd_wen_o, is_load_o;
   logic [31:0] instr, pc_plus4, ex_result, wb_wdata, rdata1, rdata2, pc_plus4_o;
   logic [23:0] ctrl, ctrl_o;
   logic [4:0]  wb_waddr, rd_addr_o;
   logic [15:0] bubble_cnt;

   logic        s_valid, s_ready, s_used1, s_wen, s_ld, s_wb_wen;
   logic        s_ex_valid, s_rd_wen_o, s_is_load_o;
   logic [31:0] s_instr, s_wb_wdata, s_rdata1, s_rdata2, s_pc_o;
   logic [23:0] s_ctrl_o;
   logic [3:0]  s_wb_waddr, s_rd_addr_o;
   logic [1:0]  s_bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic        u1, u2, wen, ld, flush, exrdy;
      logic [31:0] exres;
      logic        wbwen;
      logic [4:0]  wbaddr;
      logic [31:0] wbdata;
      logic        exp_ready;
      int          kind;
      logic [31:0] exp_r1, exp_r2;
      logic [15:0] exp_bub;
   } vec_t;

   typedef struct {
      logic [31:0] r1, r2, pc;
      logic [4:0]  rd;
      logic        wen, ld;
      logic [23:0] ctrl;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   exp_t cur;

   id_ex_stage_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
      .instr_i(instr), .pc_plus4_i(pc_plus4), .ctrl_i(ctrl),
      .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_wen_i(rd_wen), .is_load_i(is_load),
      .flush_i(flush), .ex_ready_i(ex_ready), .ex_result_i(ex_result),
      .wb_wen_i(wb_wen), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .ex_valid_o(ex_valid), .rdata1_o(rdata1), .rdata2_o(rdata2), .rd_addr_o(rd_addr_o),
      .rd_wen_o(rd_wen_o), .is_load_o(is_load_o), .pc_plus4_o(pc_plus4_o), .ctrl_o(ctrl_o),
      .bubble_cnt_o(bubble_cnt)
   );

   id_ex_stage_pipe #(.NUM_REGS(16), .CNT_WIDTH(2)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .instr_valid_i(s_valid), .instr_ready_o(s_ready),
      .instr_i(s_instr), .pc_plus4_i(32'h0000_0200), .ctrl_i(24'h00_0055),
      .rs1_used_i(s_used1), .rs2_used_i(1'b0), .rd_wen_i(s_wen), .is_load_i(s_ld),
      .flush_i(1'b0), .ex_ready_i(1'b1), .ex_result_i(32'h0000_0BAD),
      .wb_wen_i(s_wb_wen), .wb_waddr_i(s_wb_waddr), .wb_wdata_i(s_wb_wdata),
      .ex_valid_o(s_ex_valid), .rdata1_o(s_rdata1), .rdata2_o(s_rdata2), .rd_addr_o(s_rd_addr_o),
      .rd_wen_o(s_rd_wen_o), .is_load_o(s_is_load_o), .pc_plus4_o(s_pc_o), .ctrl_o(s_ctrl_o),
      .bubble_cnt_o(s_bubble_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic vec_t mkv(input logic valid, input logic [31:0] ins,
                                input logic u1, input logic u2, input logic wen, input logic ld,
                                input logic fl, input logic exrdy, input logic [31:0] exres,
                                input logic wbwen, input logic [4:0] wbaddr, input logic [31:0] wbdata,
                                input logic exp_ready, input int kind,
                                input logic [31:0] r1, input logic [31:0] r2, input logic [15:0] bub);
      vec_t t;
      t.valid = valid; t.instr = ins; t.u1 = u1; t.u2 = u2; t.wen = wen; t.ld = ld;
      t.flush = fl; t.exrdy = exrdy; t.exres = exres;
      t.wbwen = wbwen; t.wbaddr = wbaddr; t.wbdata = wbdata;
      t.exp_ready = exp_ready; t.kind = kind; t.exp_r1 = r1; t.exp_r2 = r2; t.exp_bub = bub;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic apply_stimulus(input vec_t t, input int idx);
      exp_t e;
      @(negedge clk);
      instr_valid = t.valid; instr = t.instr;
      pc_plus4 = 32'h0000_1000 + 32'(idx * 4);
      ctrl = 24'h00_A000 | 24'(idx + 1);
      rs1_used = t.u1; rs2_used = t.u2; rd_wen = t.wen; is_load = t.ld;
      flush = t.flush; ex_ready = t.exrdy; ex_result = t.exres;
      wb_wen = t.wbwen; wb_waddr = t.wbaddr; wb_wdata = t.wbdata;
      #1;
      check($sformatf("vec%0d instr_ready", idx), 64'(instr_ready), 64'(t.exp_ready));
      if (t.kind == KIND_LOAD) begin
         e.r1 = t.exp_r1; e.r2 = t.exp_r2; e.rd = t.instr[11:7];
         e.wen = t.wen; e.ld = t.ld; e.pc = pc_plus4; e.ctrl = ctrl;
         sb_q.push_back(e);
      end
   endtask

   task automatic check_output(input vec_t t, input int idx);
      @(posedge clk);
      #1;
      if (t.kind == KIND_LOAD) begin
         if (sb_q.size() == 0) begin
            check($sformatf("vec%0d scoreboard", idx), 64'd0, 64'd1);
         end else begin
            cur = sb_q.pop_front();
         end
      end
      if (t.kind == KIND_BUBBLE) begin
         check($sformatf("vec%0d ex_valid", idx), 64'(ex_valid), 64'd0);
         check($sformatf("vec%0d rd_wen", idx), 64'(rd_wen_o), 64'd0);
         check($sformatf("vec%0d is_load", idx), 64'(is_load_o), 64'd0);
         check($sformatf("vec%0d ctrl", idx), 64'(ctrl_o), 64'd0);
      end else begin
         check($sformatf("vec%0d ex_valid", idx), 64'(ex_valid), 64'd1);
         check($sformatf("vec%0d rdata1", idx), 64'(rdata1), 64'(cur.r1));
         check($sformatf("vec%0d rdata2", idx), 64'(rdata2), 64'(cur.r2));
         check($sformatf("vec%0d rd_addr", idx), 64'(rd_addr_o), 64'(cur.rd));
         check($sformatf("vec%0d rd_wen", idx), 64'(rd_wen_o), 64'(cur.wen));
         check($sformatf("vec%0d is_load", idx), 64'(is_load_o), 64'(cur.ld));
         check($sformatf("vec%0d pc_plus4", idx), 64'(pc_plus4_o), 64'(cur.pc));
         check($sformatf("vec%0d ctrl", idx), 64'(ctrl_o), 64'(cur.ctrl));
      end
      check($sformatf("vec%0d bubble_cnt", idx), 64'(bubble_cnt), 64'(t.exp_bub));
   endtask

   task automatic step16(input logic valid, input logic [31:0] ins, input logic u1,
                         input logic wen, input logic ld, input logic wbwen,
                         input logic [3:0] wbaddr, input logic [31:0] wbdata);
      @(negedge clk);
      s_valid = valid; s_instr = ins; s_used1 = u1; s_wen = wen; s_ld = ld;
      s_wb_wen = wbwen; s_wb_waddr = wbaddr; s_wb_wdata = wbdata;
   endtask

   initial begin
      rst_n = 1'b0;
      instr_valid = 0; instr = '0; pc_plus4 = '0; ctrl = '0; rs1_used = 0; rs2_used = 0;
      rd_wen = 0; is_load = 0; flush = 0; ex_ready = 1; ex_result = '0;
      wb_wen = 0; wb_waddr = '0; wb_wdata = '0;
      s_valid = 0; s_instr = '0; s_used1 = 0; s_wen = 0; s_ld = 0;
      s_wb_wen = 0; s_wb_waddr = '0; s_wb_wdata = '0;

      // args: valid instr u1 u2 wen ld flush exrdy exres wbwen wbaddr wbdata | ready kind r1 r2 bub
      vecs.push_back(mkv(1, enc(1, 5, 0), 1, 0, 0, 0, 0, 1, 32'h0, 1, 5'd5, 32'hDEAD_BEEF,
                         1, KIND_LOAD, 32'hDEAD_BEEF, 32'h0, 16'd0));
      vecs.push_back(mkv(1, enc(2, 0, 5), 1, 1, 0, 0, 0, 1, 32'h5555, 1, 5'd0, 32'h1234,
                         1, KIND_LOAD, 32'h0, 32'hDEAD_BEEF, 16'd0));
      vecs.push_back(mkv(1, enc(3, 0, 0), 0, 0, 1, 0, 0, 1, 32'h7777, 0, 5'd0, 32'h0,
                         1, KIND_LOAD, 32'h0, 32'h0, 16'd0));
      vecs.push_back(mkv(1, enc(4, 3, 3), 1, 1, 1, 0, 0, 1, 32'h10, 0, 5'd0, 32'h0,
                         1, KIND_LOAD, 32'h10, 32'h10, 16'd0));
      vecs.push_back(mkv(1, enc(7, 0, 0), 1, 0, 1, 1, 0, 1, 32'h99, 1, 5'd3, 32'h10,
                         1, KIND_LOAD, 32'h0, 32'h0, 16'd0));
      vecs.push_back(mkv(1, enc(8, 7, 1), 1, 1, 1, 0, 0, 1, 32'hBAD, 0, 5'd0, 32'h0,
                         0, KIND_BUBBLE, 32'h0, 32'h0, 16'd1));
      vecs.push_back(mkv(1, enc(8, 7, 1), 1, 1, 1, 0, 0, 1, 32'hBAD, 1, 5'd7, 32'hCAFE,
                         1, KIND_LOAD, 32'hCAFE, 32'h0, 16'd1));
      vecs.push_back(mkv(1, enc(9, 7, 5), 1, 1, 1, 0, 0, 1, 32'h1111, 0, 5'd0, 32'h0,
                         1, KIND_LOAD, 32'hCAFE, 32'hDEAD_BEEF, 16'd1));
      for (int k = 0; k < 3; k++) begin
         vecs.push_back(mkv(1, enc(10, 9, 9), 1, 1, 1, 0, 0, 0, 32'h2222, 0, 5'd0, 32'h0,
                            0, KIND_HOLD, 32'h0, 32'h0, 16'd1));
      end
      vecs.push_back(mkv(1, enc(10, 9, 9), 1, 1, 1, 0, 1, 1, 32'h2222, 0, 5'd0, 32'h0,
                         1, KIND_BUBBLE, 32'h0, 32'h0, 16'd1));
      vecs.push_back(mkv(0, enc(0, 0, 0), 0, 0, 0, 0, 0, 1, 32'h0, 0, 5'd0, 32'h0,
                         1, KIND_BUBBLE, 32'h0, 32'h0, 16'd1));
      vecs.push_back(mkv(1, enc(6, 0, 0), 1, 0, 1, 1, 0, 1, 32'h0, 0, 5'd0, 32'h0,
                         1, KIND_LOAD, 32'h0, 32'h0, 16'd1));
      vecs.push_back(mkv(1, enc(11, 6, 0), 1, 0, 1, 0, 1, 1, 32'h3333, 0, 5'd0, 32'h0,
                         1, KIND_BUBBLE, 32'h0, 32'h0, 16'd1));
      vecs.push_back(mkv(1, enc(6, 0, 0), 1, 0, 1, 1, 0, 1, 32'h0, 0, 5'd0, 32'h0,
                         1, KIND_LOAD, 32'h0, 32'h0, 16'd1));
      vecs.push_back(mkv(1, enc(12, 0, 6), 1, 0, 1, 0, 0, 1, 32'h4444, 0, 5'd0, 32'h0,
                         1, KIND_LOAD, 32'h0, 32'h0, 16'd1));

      repeat (2) @(negedge clk);
      check("reset ex_valid", 64'(ex_valid), 64'd0);
      check("reset bubble_cnt", 64'(bubble_cnt), 64'd0);
      check("reset rdata1", 64'(rdata1), 64'd0);
      check("reset ctrl", 64'(ctrl_o), 64'd0);
      check("reset instr_ready", 64'(instr_ready), 64'd1);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i], i);
         check_output(vecs[i], i);
      end
      check("scoreboard drained", 64'(sb_q.size()), 64'd0);

      // Reset asserted mid-cycle with a valid occupant in EX.
      @(negedge clk);
      instr_valid = 1; instr = enc(13, 5, 0); rs1_used = 1; rs2_used = 0;
      rd_wen = 1; is_load = 0; flush = 0; ex_ready = 1; wb_wen = 0;
      @(posedge clk);
      #1;
      check("pre-reset ex_valid", 64'(ex_valid), 64'd1);
      check("pre-reset rdata1", 64'(rdata1), 64'hDEAD_BEEF);
      #1 rst_n = 1'b0;
      #1;
      check("midreset ex_valid", 64'(ex_valid), 64'd0);
      check("midreset bubble_cnt", 64'(bubble_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      instr = enc(14, 5, 5); rs2_used = 1;
      @(posedge clk);
      #1;
      check("post-reset ex_valid", 64'(ex_valid), 64'd1);
      check("post-reset x5 rs1", 64'(rdata1), 64'd0);
      check("post-reset x5 rs2", 64'(rdata2), 64'd0);
      @(negedge clk);
      instr_valid = 0;

      // 16-register instance: field 0x13 aliases x3, counter saturates at 3.
      step16(0, 32'h0, 0, 0, 0, 1, 4'd3, 32'h33);
      step16(1, enc(1, 5'h13, 0), 1, 1, 0, 0, 4'd0, 32'h0);
      @(posedge clk);
      #1;
      check("r16 rs1=0x13 reads x3", 64'(s_rdata1), 64'h33);
      check("r16 rd_addr", 64'(s_rd_addr_o), 64'd1);
      for (int r = 0; r < 5; r++) begin
         step16(1, enc(2, 0, 0), 1, 1, 1, 0, 4'd0, 32'h0);
         step16(1, enc(5, 2, 0), 1, 1, 0, 0, 4'd0, 32'h0);
         #1;
         check($sformatf("r16 round%0d ready", r), 64'(s_ready), 64'd0);
         @(posedge clk);
         #1;
         check($sformatf("r16 round%0d ex_valid", r), 64'(s_ex_valid), 64'd0);
         check($sformatf("r16 round%0d bubble_cnt", r), 64'(s_bubble_cnt), 64'((r + 1 > 3) ? 3 : r + 1));
      end
      step16(0, 32'h0, 0, 0, 0, 0, 4'd0, 32'h0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
